// File: rtl/regs_wb_arb_if.sv
// rtl/regs_wb_arb_if.sv - write-back request, scoreboard and regs write-port bundle
interface regs_wb_arb_if;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        b_ready;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        hz1;
    logic        hz2;
    logic [31:0] pend;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  iss_valid, iss_addr, raddr1, raddr2,
        output a_ready, b_ready, hz1, hz2, pend, we, waddr, wdata
    );

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output iss_valid, iss_addr, raddr1, raddr2,
        input  a_ready, b_ready, hz1, hz2, pend, we, waddr, wdata
    );
endinterface

// File: rtl/regs_wb_arb.sv
// rtl/regs_wb_arb.sv - write-back arbiter with B anti-starvation and pending-write scoreboard
module regs_wb_arb #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic         clk,
    input  logic         rst,
    regs_wb_arb_if.slave bus
);

    localparam logic [CNT_W-1:0] SAT_VAL = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pend_q, pend_d;
    logic             we_q;
    logic [4:0]       waddr_q;
    logic [31:0]      wdata_q;

    logic sat;
    logic a_rdy, b_rdy;
    logic a_acc, b_acc;

    // A wins unless B has waited long enough; the two grants are mutually exclusive.
    assign sat   = (cnt_q == SAT_VAL);
    assign a_rdy = !(bus.b_valid && sat);
    assign b_rdy = !bus.a_valid || sat;
    assign a_acc = bus.a_valid && a_rdy;
    assign b_acc = bus.b_valid && b_rdy;

    assign bus.a_ready = a_rdy;
    assign bus.b_ready = b_rdy;
    assign bus.hz1     = pend_q[bus.raddr1];
    assign bus.hz2     = pend_q[bus.raddr2];
    assign bus.pend    = pend_q;
    assign bus.we      = we_q;
    assign bus.waddr   = waddr_q;
    assign bus.wdata   = wdata_q;

    always_comb begin
        cnt_d = '0;
        if (bus.b_valid && !b_rdy) begin
            cnt_d = sat ? cnt_q : cnt_q + 1'b1;
        end
    end

    // Issue is applied after the completion clear so a same-cycle reissue stays pending.
    always_comb begin
        pend_d = pend_q;
        if (b_acc) begin
            pend_d[bus.b_addr] = 1'b0;
        end
        if (bus.iss_valid && (bus.iss_addr != 5'd0)) begin
            pend_d[bus.iss_addr] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            pend_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            if (b_acc) begin
                we_q    <= (bus.b_addr != 5'd0);
                waddr_q <= bus.b_addr;
                wdata_q <= bus.b_data;
            end else if (a_acc) begin
                we_q    <= (bus.a_addr != 5'd0);
                waddr_q <= bus.a_addr;
                wdata_q <= bus.a_data;
            end else begin
                we_q <= 1'b0;
            end
        end
    end

endmodule

// File: doc/regs_wb_arb.md
Name: regs_wb_arb

Overview:
- Write-back arbiter and pending-write scoreboard for the 32x32 integer register file, which has a single write port.
- Shares that write port between two sources:
  - A: the in-order execute pipeline.
  - B: the long-latency mul/div/load unit.
- A has priority; B is protected against starvation by an aging counter.
- Tracks registers with outstanding B writes and flags read hazards for both decode read ports.
- Sits between execute/long-latency units and regs; its we/waddr/wdata drive the regs write port directly.

Parameters:
- STARVE_LIMIT, 4, number of consecutive cycles B may wait before it overrides A (1..7).
- CNT_W, 3, width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- a_valid  in  1  pipeline write-back request.
- a_addr  in  5  destination register for A.
- a_data  in  32  write data for A.
- a_ready  out  1  A accepted this cycle when a_valid=1.
- b_valid  in  1  long-latency unit write-back request.
- b_addr  in  5  destination register for B.
- b_data  in  32  write data for B.
- b_ready  out  1  B accepted this cycle when b_valid=1.
- iss_valid  in  1  a long-latency op is issued this cycle.
- iss_addr  in  5  destination register of the issued op.
- raddr1  in  5  decode read address, port 1.
- raddr2  in  5  decode read address, port 2.
- hz1  out  1  raddr1 has a pending B write (decode must stall).
- hz2  out  1  raddr2 has a pending B write.
- pend  out  32  scoreboard bitmap; bit i = register i pending.
- we  out  1  regs write enable (registered).
- waddr  out  5  regs write address (registered).
- wdata  out  32  regs write data (registered).

Behaviour:
- Reset (rst=0, asynchronous): we=0, waddr=0, wdata=0, pend=0, starve counter=0. Combinational outputs follow from the cleared state.
- A reset asserted mid-transfer discards the accepted-but-unwritten entry and all pending bits.
- Handshake: a transfer occurs on a cycle where valid=1 and ready=1. Requesters hold addr/data stable while valid=1 and not ready.
- Starvation state: sat = (cnt == STARVE_LIMIT).
- Ready logic (combinational):
  - a_ready = !(b_valid && sat).
  - b_ready = !a_valid || sat.
  - At most one source is accepted per cycle.
- Counter update:
  - cnt+1 when b_valid=1 and b_ready=0, saturating at STARVE_LIMIT.
  - cnt=0 when B is accepted or b_valid=0.
- Output register: one-cycle latency from acceptance to the write at regs.
  - On acceptance: we <= (addr != 0); waddr/wdata <= the selected source's addr/data.
  - A write to x0 is consumed (ready asserted) but produces we=0.
  - No acceptance: we <= 0; waddr/wdata hold their previous values.
- Scoreboard:
  - Set pend[iss_addr] on iss_valid when iss_addr != 0.
  - Clear pend[b_addr] on B acceptance.
  - Clearing at accept is correct because regs forwards same-cycle write data to its readers one cycle later.
  - Set and clear of the same register in the same cycle: set wins, since it is a new issue.
  - pend[0] is always 0.
- Hazards (combinational):
  - hz1 = pend[raddr1]; hz2 = pend[raddr2].
  - Both reflect state registered before the current edge: an iss_valid this cycle does not raise hz until next cycle. Decode interlock covers that case.
- B write to a register whose pend bit is 0 is still written; pend is unaffected.
- A writing a register with pend=1 is not checked by this block; the issue unit prevents it.

Test Plan:
- After reset release, a_valid=1, a_addr=5, a_data=0x1234 -> a_ready=1 same cycle; next cycle we=1, waddr=5, wdata=0x1234.
- a_valid and b_valid held high continuously, STARVE_LIMIT=4 -> A granted for cycles 0..3. Cycle 4: b_ready=1, a_ready=0; B written next cycle; counter returns to 0 and A resumes.
- iss_valid=1, iss_addr=7, then raddr1=7 -> hz1=1 and pend[7]=1 from the next cycle. B completes to addr 7 -> pend[7]=0 and hz1=0 the cycle after acceptance, while we=1, waddr=7.
- Same cycle: iss_valid=1, iss_addr=9, and B accepted with b_addr=9 -> pend[9] remains 1.
- a_valid=1, a_addr=0 -> a_ready=1, next-cycle we=0. iss_addr=0 -> pend stays 0.
- Drive rst=0 asynchronously mid-cycle with pend=0x00000880 and we=1 -> pend=0, we=0, waddr=0, wdata=0 immediately, without waiting for a clock edge.
